// File: rtl/multi_control_seq_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states,
// instruction opcodes and ALU operation codes.
package multi_control_seq_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_MULW   = 4'd5,
    S_HLT    = 4'd6,
    S_ERR    = 4'd7
  } state_e;

  localparam int unsigned INS_NOP  = 0;
  localparam int unsigned INS_ADD  = 1;
  localparam int unsigned INS_SUB  = 2;
  localparam int unsigned INS_LI   = 3;
  localparam int unsigned INS_LD   = 4;
  localparam int unsigned INS_ST   = 5;
  localparam int unsigned INS_BEQ  = 6;
  localparam int unsigned INS_MUL  = 7;
  localparam int unsigned INS_HALT = 31;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_MUL  = 2;
  localparam int unsigned OP_PASS = 3;

  // States that block on an external handshake and are therefore guarded.
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM) || (s == S_MULW);
  endfunction

endpackage

// File: rtl/multi_control_seq_handshake_watchdog.sv
// Counts cycles spent waiting on a handshake; flags a timeout in the cycle
// the wait would exceed MAX_WAIT unless the handshake arrives in that cycle.
module handshake_watchdog #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic count_en,
  input  logic done,
  output logic timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  assign timeout = count_en && !done && (cnt_q == LAST);

  // Saturates at LAST so a stalled counter can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !done && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multi_control_seq.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory and multiplier handshakes guarded by a watchdog.
module multi_control_seq
  import multi_control_seq_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int ALUOP_W  = 5,
  parameter int MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  zero_flag,
  input  logic                  mem_ack,
  input  logic                  alu_done,
  input  logic                  run,
  output logic                  ireg_enable,
  output logic                  write_enable,
  output logic                  imm_mux,
  output logic                  wb_sel,
  output logic [ALUOP_W-1:0]    aluOP,
  output logic                  alu_start,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_mux,
  output logic                  pc_enable,
  output logic                  pc_src,
  output logic                  retire,
  output logic                  halted,
  output logic                  error,
  output logic [STATE_BITS-1:0] dbg_state_o
);

  state_e state_q;
  state_e state_d;
  logic   wait_en;
  logic   hs_done;
  logic   timeout;
  logic   wd_clear;

  // Only the handshake belonging to the current wait state counts.
  assign wait_en     = !reset && is_wait_state(state_q);
  assign hs_done     = (state_q == S_MULW) ? alu_done : mem_ack;
  assign wd_clear    = reset || (state_d != state_q);
  assign dbg_state_o = state_q;

  handshake_watchdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_watchdog (
    .clk     (clk),
    .clear   (wd_clear),
    .count_en(wait_en),
    .done    (hs_done),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ireg_enable  = 1'b0;
    write_enable = 1'b0;
    imm_mux      = 1'b1;
    wb_sel       = 1'b0;
    aluOP        = ALUOP_W'(OP_PASS);
    alu_start    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_mux     = 1'b0;
    pc_enable    = 1'b0;
    pc_src       = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    error        = 1'b0;

    if (reset) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ireg_enable = 1'b1;
            pc_enable   = 1'b1;
            state_d     = S_DECODE;
          end else if (timeout) begin
            state_d = S_ERR;
          end
        end

        S_DECODE: begin
          case (opcode)
            OPCODE_W'(INS_NOP): begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            OPCODE_W'(INS_LI): begin
              write_enable = 1'b1;
              imm_mux      = 1'b0;
              retire       = 1'b1;
              state_d      = S_FETCH;
            end
            OPCODE_W'(INS_ADD),
            OPCODE_W'(INS_SUB),
            OPCODE_W'(INS_BEQ):  state_d = S_EXEC;
            OPCODE_W'(INS_LD),
            OPCODE_W'(INS_ST):   state_d = S_MEM;
            OPCODE_W'(INS_MUL): begin
              alu_start = 1'b1;
              aluOP     = ALUOP_W'(OP_MUL);
              state_d   = S_MULW;
            end
            OPCODE_W'(INS_HALT): state_d = S_HLT;
            default:             state_d = S_ERR;
          endcase
        end

        S_EXEC: begin
          case (opcode)
            OPCODE_W'(INS_ADD): begin
              aluOP        = ALUOP_W'(OP_ADD);
              write_enable = 1'b1;
              retire       = 1'b1;
            end
            OPCODE_W'(INS_SUB): begin
              aluOP        = ALUOP_W'(OP_SUB);
              write_enable = 1'b1;
              retire       = 1'b1;
            end
            OPCODE_W'(INS_BEQ): begin
              aluOP     = ALUOP_W'(OP_SUB);
              pc_enable = zero_flag;
              pc_src    = zero_flag;
              retire    = 1'b1;
            end
            default: ;
          endcase
          state_d = S_FETCH;
        end

        S_MEM: begin
          aluOP    = ALUOP_W'(OP_ADD);
          mem_req  = 1'b1;
          addr_mux = 1'b1;
          mem_we   = (opcode == OPCODE_W'(INS_ST));
          if (mem_ack) begin
            if (opcode == OPCODE_W'(INS_ST)) begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (timeout) begin
            state_d = S_ERR;
          end
        end

        S_WB: begin
          write_enable = 1'b1;
          wb_sel       = 1'b1;
          retire       = 1'b1;
          state_d      = S_FETCH;
        end

        S_MULW: begin
          aluOP = ALUOP_W'(OP_MUL);
          if (alu_done) begin
            write_enable = 1'b1;
            retire       = 1'b1;
            state_d      = S_FETCH;
          end else if (timeout) begin
            state_d = S_ERR;
          end
        end

        S_HLT: begin
          halted = 1'b1;
          if (run) state_d = S_FETCH;
        end

        S_ERR: begin
          error = 1'b1;
        end

        default: state_d = S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_control_seq.sv
// Directed bench for multi_control_seq: each instruction is expanded into its
// expected per-cycle output trace and compared against the DUT every cycle.
module tb_multi_control_seq;

  localparam int MAX_WAIT = 16;
  localparam int W        = 18;

  localparam int NOP = 0, ADD = 1, SUB = 2, LI = 3, LD = 4, ST = 5;
  localparam int BEQ = 6, MUL = 7, HALT = 31;

  typedef struct packed {
    logic       ir;
    logic       we;
    logic       imm;
    logic       wb;
    logic [4:0] op;
    logic       st;
    logic       mr;
    logic       mw;
    logic       am;
    logic       pe;
    logic       ps;
    logic       ret;
    logic       h;
    logic       e;
  } outs_t;

  // Clock / reset and DUT signals
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic       zero_flag, mem_ack, alu_done, run;
  logic       ireg_enable, write_enable, imm_mux, wb_sel;
  logic [4:0] aluOP;
  logic       alu_start, mem_req, mem_we, addr_mux, pc_enable, pc_src;
  logic       retire, halted, error;
  logic [3:0] dbg_state;

  logic [W-1:0] act;
  logic [W-1:0] exp_q[$];
  outs_t        hist[$];
  int           checks = 0;
  int           errors = 0;
  string        tag = "init";
  bit           dead;

  always #5 clk = ~clk;

  assign act = {ireg_enable, write_enable, imm_mux, wb_sel, aluOP, alu_start,
                mem_req, mem_we, addr_mux, pc_enable, pc_src, retire, halted, error};

  multi_control_seq #(
    .OPCODE_W(5),
    .ALUOP_W (5),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero_flag   (zero_flag),
    .mem_ack     (mem_ack),
    .alu_done    (alu_done),
    .run         (run),
    .ireg_enable (ireg_enable),
    .write_enable(write_enable),
    .imm_mux     (imm_mux),
    .wb_sel      (wb_sel),
    .aluOP       (aluOP),
    .alu_start   (alu_start),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_mux    (addr_mux),
    .pc_enable   (pc_enable),
    .pc_src      (pc_src),
    .retire      (retire),
    .halted      (halted),
    .error       (error),
    .dbg_state_o (dbg_state)
  );

  // Scoreboard: one expected vector per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s t=%0t outputs act=%h exp=%h", tag, $time, act, e);
      end
    end
  end

  function automatic outs_t d0();
    outs_t o;
    o     = '0;
    o.imm = 1'b1;
    o.op  = 5'd3;
    return o;
  endfunction

  task automatic lit(input string name, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, a, e);
    end
  endtask

  // Inputs are already set; record the DUT, queue the expectation, advance.
  task automatic cyc(input outs_t e);
    #1;
    hist.push_back(outs_t'(act));
    exp_q.push_back(W'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic err_cycles(input int n);
    outs_t e;
    e = d0();
    e.e = 1'b1;
    mem_ack = 1'b1; alu_done = 1'b1; run = 1'b1;
    for (int i = 0; i < n; i++) cyc(e);
    run  = 1'b0;
    dead = 1'b1;
  endtask

  task automatic do_reset(input int n);
    hist.delete();
    reset     = 1'b1;
    opcode    = 5'($urandom_range(0, 31));
    zero_flag = 1'b1; mem_ack = 1'b1; alu_done = 1'b1; run = 1'b1;
    for (int i = 0; i < n; i++) cyc(d0());
    reset = 1'b0; mem_ack = 1'b0; alu_done = 1'b0; run = 1'b0;
    dead  = 1'b0;
  endtask

  // Fetch waits fw cycles for mem_ack; MAX_WAIT silent cycles mean error.
  task automatic fetch(input int fw);
    outs_t e;
    e = d0();
    e.mr = 1'b1;
    mem_ack = 1'b0; alu_done = 1'b1;
    for (int i = 0; i < fw && i < MAX_WAIT; i++) cyc(e);
    if (fw >= MAX_WAIT) begin
      err_cycles(3);
      return;
    end
    mem_ack = 1'b1;
    e.ir = 1'b1;
    e.pe = 1'b1;
    cyc(e);
  endtask

  task automatic instr(input int op, input bit zf, input int fw, input int xw);
    outs_t e;
    hist.delete();
    dead = 1'b0;
    opcode = 5'(op); zero_flag = zf; run = 1'b0;
    fetch(fw);
    if (dead) return;
    mem_ack = 1'b1; alu_done = 1'b1;
    e = d0();
    case (op)
      NOP: begin e.ret = 1'b1; cyc(e); end
      LI: begin e.we = 1'b1; e.imm = 1'b0; e.ret = 1'b1; cyc(e); end
      ADD, SUB, BEQ: begin
        cyc(e);
        e = d0();
        e.op = (op == ADD) ? 5'd0 : 5'd1;
        if (op == BEQ) begin e.pe = zf; e.ps = zf; end
        else e.we = 1'b1;
        e.ret = 1'b1;
        cyc(e);
      end
      LD, ST: begin
        cyc(e);
        e = d0();
        e.op = 5'd0; e.mr = 1'b1; e.am = 1'b1; e.mw = (op == ST);
        mem_ack = 1'b0;
        for (int i = 0; i < xw && i < MAX_WAIT; i++) cyc(e);
        if (xw >= MAX_WAIT) begin err_cycles(3); return; end
        mem_ack = 1'b1;
        if (op == ST) e.ret = 1'b1;
        cyc(e);
        if (op == LD) begin
          e = d0(); e.we = 1'b1; e.wb = 1'b1; e.ret = 1'b1;
          cyc(e);
        end
      end
      MUL: begin
        e.st = 1'b1; e.op = 5'd2;
        cyc(e);
        e = d0(); e.op = 5'd2;
        alu_done = 1'b0;
        for (int i = 0; i < xw && i < MAX_WAIT; i++) cyc(e);
        if (xw >= MAX_WAIT) begin err_cycles(3); return; end
        alu_done = 1'b1;
        e.we = 1'b1; e.ret = 1'b1;
        cyc(e);
      end
      HALT: begin
        cyc(e);
        e = d0(); e.h = 1'b1;
        run = 1'b0;
        for (int i = 0; i < xw; i++) cyc(e);
        run = 1'b1;
        cyc(e);
        run = 1'b0;
      end
      default: begin
        cyc(e);
        err_cycles(3);
        return;
      end
    endcase
    mem_ack = 1'b0; alu_done = 1'b0;
  endtask

  initial begin
    outs_t e;
    reset = 1'b1; opcode = '0; zero_flag = 1'b0;
    mem_ack = 1'b0; alu_done = 1'b0; run = 1'b0;
    @(posedge clk);
    #1;

    tag = "reset"; do_reset(2);
    lit("reset_defaults", W'(hist[1]), 18'h08600);

    tag = "li"; instr(LI, 1'b0, 0, 0);
    lit("li_c1_ireg", W'(hist[0].ir), 1);
    lit("li_c1_pc_en", W'(hist[0].pe), 1);
    lit("li_c2_we", W'(hist[1].we), 1);
    lit("li_c2_imm_mux", W'(hist[1].imm), 0);
    lit("li_c2_retire", W'(hist[1].ret), 1);
    lit("li_len", hist.size(), 2);

    tag = "nop"; instr(NOP, 1'b0, 0, 0);
    tag = "add"; instr(ADD, 1'b0, 1, 0);
    lit("add_exec_aluop", W'(hist[3].op), 0);
    lit("add_exec_we", W'(hist[3].we), 1);
    tag = "beq_taken"; instr(BEQ, 1'b1, 0, 0);
    lit("beq_t_pc_src", W'(hist[2].ps), 1);
    lit("beq_t_pc_en", W'(hist[2].pe), 1);
    tag = "beq_not"; instr(BEQ, 1'b0, 0, 0);
    lit("beq_n_pc_en", W'(hist[2].pe), 0);
    tag = "sub"; instr(SUB, 1'b1, 0, 0);

    tag = "ld"; instr(LD, 1'b0, 0, 3);
    for (int i = 2; i < 6; i++) begin
      lit("ld_mem_req", W'(hist[i].mr), 1);
      lit("ld_addr_mux", W'(hist[i].am), 1);
      lit("ld_mem_we", W'(hist[i].mw), 0);
    end
    lit("ld_wb_sel", W'(hist[6].wb), 1);
    lit("ld_wb_we", W'(hist[6].we), 1);
    tag = "st"; instr(ST, 1'b0, 0, 3);
    lit("st_mem_we", W'(hist[2].mw), 1);
    lit("st_retire", W'(hist[5].ret), 1);
    lit("st_len", hist.size(), 6);

    tag = "mul"; instr(MUL, 1'b0, 0, 5);
    lit("mul_start_dec", W'(hist[1].st), 1);
    lit("mul_start_once", W'(hist[2].st), 0);
    lit("mul_we_early", W'(hist[6].we), 0);
    lit("mul_we_done", W'(hist[7].we), 1);

    tag = "wd_fetch"; instr(NOP, 1'b0, 16, 0);
    lit("wd_fetch_c16", W'(hist[15].e), 0);
    lit("wd_fetch_c17", W'(hist[16].e), 1);
    lit("wd_fetch_sticky", W'(hist[18].e), 1);
    do_reset(1);
    tag = "wd_fetch_edge"; instr(LI, 1'b0, 15, 0);
    lit("wd_edge_decode", W'(hist[15].ir), 1);
    lit("wd_edge_no_err", W'(hist[16].e), 0);
    lit("wd_edge_we", W'(hist[16].we), 1);

    tag = "wd_mem"; instr(LD, 1'b0, 0, 16);
    lit("wd_mem_err", W'(hist[18].e), 1);
    do_reset(1);
    tag = "wd_mulw"; instr(MUL, 1'b0, 0, 16);
    do_reset(1);
    tag = "st_edge"; instr(ST, 1'b0, 0, 15);

    tag = "halt"; instr(HALT, 1'b0, 0, 2);
    lit("halt_halted", W'(hist[2].h), 1);
    tag = "after_halt"; instr(ADD, 1'b0, 0, 0);

    tag = "illegal"; instr(9, 1'b0, 0, 0);
    lit("illegal_err", W'(hist[2].e), 1);
    tag = "reset_from_err"; do_reset(1);
    tag = "after_err"; instr(LI, 1'b0, 0, 0);

    tag = "reset_mulw";
    hist.delete();
    opcode = 5'(MUL); zero_flag = 1'b0; run = 1'b0;
    fetch(0);
    mem_ack = 1'b0; alu_done = 1'b0;
    e = d0(); e.st = 1'b1; e.op = 5'd2;
    cyc(e);
    e = d0(); e.op = 5'd2;
    cyc(e);
    cyc(e);
    do_reset(1);
    lit("reset_mulw_defaults", W'(hist[0]), 18'h08600);
    tag = "after_mulw_reset"; instr(LI, 1'b0, 0, 0);
    lit("after_reset_fetch", W'(hist[0].mr), 1);

    begin
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain left=%0d exp=0", exp_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
